gated_sample_reader: RTL and testbench

- Read-side counterpart to the team's enable-gated hold element (output follows data while enable is high, otherwise holds).
- Captures a W-bit data word on each clock edge where `en` is high and buffers it in a DEPTH-entry FIFO.
- A consumer drains the FIFO through a valid/ready handshake.
- Output `q` holds the most recently drained word until the next successful read, so downstream logic sees the same hold semantics one stage later.

---
 rtl/gated_sample_reader_if.sv | 39 +++
 rtl/gated_sample_reader.sv | 103 ++++++++++
 tb/tb_gated_sample_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gated_sample_reader_if.sv
// Handshake bundle for gated_sample_reader: capture side (en/d) and
// drain side (rd_valid/rd_ready/rd_data), plus the held output and status.
// The optional sticky overflow flag appears when
// GATED_SAMPLE_READER_OVF_STICKY_EN is defined.
interface gated_sample_reader_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    logic                     en;
    logic [W-1:0]             d;
    logic                     rd_ready;
    logic                     rd_valid;
    logic [W-1:0]             rd_data;
    logic [W-1:0]             q;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
`ifdef GATED_SAMPLE_READER_OVF_STICKY_EN
    logic                     ovf;

    modport master (
        output en, d, rd_ready,
        input  rd_valid, rd_data, q, count, full, empty, ovf
    );
    modport slave (
        input  en, d, rd_ready,
        output rd_valid, rd_data, q, count, full, empty, ovf
    );
`else
    modport master (
        output en, d, rd_ready,
        input  rd_valid, rd_data, q, count, full, empty
    );
    modport slave (
        input  en, d, rd_ready,
        output rd_valid, rd_data, q, count, full, empty
    );
`endif
endinterface

// File: rtl/gated_sample_reader.sv
// gated_sample_reader: captures d on every enabled edge into a DEPTH-entry
// first-word-fall-through FIFO; a consumer drains it via valid/ready and q
// holds the last drained word until the next pop.
// Optional: define GATED_SAMPLE_READER_OVF_STICKY_EN for a sticky ovf flag
// that records any word dropped while full.
module gated_sample_reader #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    gated_sample_reader_if.slave         bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  q_q, q_d;
    logic          push, pop;
    logic          full_w, empty_w;

    // Status is derived only from the registered count, so no path from en/rd_ready.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_DEPTH);

    // Pop needs a valid head; a pop frees a slot, so a full FIFO still takes a push.
    assign pop  = !empty_w && bus.rd_ready;
    assign push = bus.en && (!full_w || pop);

    assign bus.rd_valid = !empty_w;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.count    = count_q;
    assign bus.q        = q_q;
    assign bus.rd_data  = empty_w ? '0 : mem[rptr_q];

    // Next-state for pointers, occupancy and the held output.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        q_d     = q_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
            q_d    = mem[rptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset discards all buffered words at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            q_q     <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            q_q     <= q_d;
        end
    end

    // Storage write on an accepted push.
    // NOTE: storage is not reset; contents are unreachable until rewritten, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.d;
        end
    end

`ifdef GATED_SAMPLE_READER_OVF_STICKY_EN
    logic ovf_q;

    assign bus.ovf = ovf_q;

    // Sticky overflow: set by any word dropped while full, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.en && full_w && !pop) begin
            ovf_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gated_sample_reader.sv
// Directed scoreboard bench for gated_sample_reader (W=8, DEPTH=4).
module tb_gated_sample_reader;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    gated_sample_reader_if #(.W(W), .DEPTH(DEPTH)) bus ();

    gated_sample_reader #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];
    int         mcount   = 0;
    logic [7:0] mq       = 8'h00;
    logic       movf     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_q"},        32'(bus.q),        32'(mq));
        check({tag, "_count"},    32'(bus.count),    32'(mcount));
        check({tag, "_full"},     32'(bus.full),     32'(mcount == DEPTH));
        check({tag, "_empty"},    32'(bus.empty),    32'(mcount == 0));
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'(mcount != 0));
`ifdef GATED_SAMPLE_READER_OVF_STICKY_EN
        check({tag, "_ovf"},      32'(bus.ovf),      32'(movf));
`endif
    endtask

    // One clock: drive inputs, check the head, update the model, clock, check state.
    task automatic cycle(input string tag, input logic en_v, input logic [7:0] d_v, input logic rdy_v);
        logic mpop;
        logic mpush;
        bus.en       = en_v;
        bus.d        = d_v;
        bus.rd_ready = rdy_v;
        #1;
        if (mcount > 0) check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(sb[0]));
        else            check({tag, "_rd_data_empty"}, 32'(bus.rd_data), 32'h0);
        mpop  = (mcount > 0) && rdy_v;
        mpush = en_v && ((mcount < DEPTH) || mpop);
        if (en_v && (mcount == DEPTH) && !mpop) movf = 1'b1;
        if (mpop)  mq = sb.pop_front();
        if (mpush) sb.push_back(d_v);
        mcount = mcount + int'(mpush) - int'(mpop);
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.d        = 8'h00;
        bus.rd_ready = 1'b0;

        // Reset asserted before any clock edge.
        #3;
        check_status("reset_noclk");
        check("reset_rd_data", 32'(bus.rd_data), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_status("post_reset");

        // Basic capture then drain.
        cycle("cap0", 1'b1, 8'h11, 1'b0);
        cycle("cap1", 1'b1, 8'h22, 1'b0);
        cycle("cap2", 1'b1, 8'h33, 1'b0);
        check("cap_count3", 32'(bus.count), 32'd3);
        check("cap_head",   32'(bus.rd_data), 32'h11);
        cycle("drain0", 1'b0, 8'h00, 1'b1);
        check("drain0_q", 32'(bus.q), 32'h11);
        cycle("drain1", 1'b0, 8'h00, 1'b1);
        cycle("drain2", 1'b0, 8'h00, 1'b1);
        check("drain_last_q", 32'(bus.q), 32'h33);
        cycle("rdy_empty", 1'b0, 8'h00, 1'b1);
        cycle("hold", 1'b0, 8'h00, 1'b0);
        check("hold_q", 32'(bus.q), 32'h33);

        // Fill to full, then drop a word.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'hA0 + 8'(i), 1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        cycle("drop", 1'b1, 8'hFF, 1'b0);
        check("drop_count", 32'(bus.count), 32'd4);
`ifdef GATED_SAMPLE_READER_OVF_STICKY_EN
        check("drop_ovf", 32'(bus.ovf), 32'd1);
`endif
        cycle("idle_full", 1'b0, 8'h00, 1'b0);

        // Simultaneous push and pop at full.
        cycle("simul", 1'b1, 8'hB0, 1'b1);
        check("simul_q",     32'(bus.q),     32'hA0);
        check("simul_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < DEPTH; i++) cycle("simul_drain", 1'b0, 8'h00, 1'b1);
        check("simul_last_q", 32'(bus.q), 32'hB0);

        // Interleaved push/pop across pointer wrap.
        for (int i = 1; i <= 10; i++) begin
            cycle("wrap_push", 1'b1, 8'(i), 1'b0);
            cycle("wrap_pop",  1'b0, 8'h00, 1'b1);
            check("wrap_q", 32'(bus.q), 32'(i));
        end

        // Reset mid-stream with no clock edge.
        cycle("ms0", 1'b1, 8'h71, 1'b0);
        cycle("ms1", 1'b1, 8'h72, 1'b0);
        cycle("ms2", 1'b1, 8'h73, 1'b1);
        bus.en       = 1'b0;
        bus.rd_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        mcount = 0;
        mq     = 8'h00;
        movf   = 1'b0;
        #1;
        check_status("midrst");
        #1;
        rst = 1'b0;
        cycle("post_rst_push", 1'b1, 8'h5A, 1'b0);
        check("post_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("post_rst_data",  32'(bus.rd_data),  32'h5A);
        cycle("post_rst_pop", 1'b0, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
